data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter DEPTH_WORDS SHALL default to 64 and SHALL set the number of 32-bit words; it SHALL be a power of two, at least 4.
REQ-003 Parameter ADDR_W SHALL default to 32 and SHALL set the byte-address width of A.
REQ-004 Port clk SHALL be an input of 1 bit: the clock; all writes occur on its rising edge.
REQ-005 Port rst_n SHALL be an input of 1 bit: the asynchronous active-low reset.
REQ-006 Port A SHALL be an input of ADDR_W bits: the byte address.
REQ-007 Port WriteData SHALL be an input of 32 bits: the store data.
REQ-008 Port WE SHALL be an input of 1 bit: write enable, active-high.
REQ-009 Port ReadData SHALL be an output of 32 bits: the load data.

Function
REQ-010 Storage SHALL be DEPTH_WORDS x 32-bit words and SHALL be word-addressed.
REQ-011 Word index SHALL be A[log2(DEPTH_WORDS)+1:2]; A[1:0] SHALL be ignored on both read and write, so no byte lanes and no misalignment trap.
REQ-012 Write SHALL be synchronous: on a rising clk edge with rst_n=1 and WE=1, mem[index] SHALL take WriteData; with WE=0 memory SHALL be unchanged.
REQ-013 Read SHALL be combinational with zero latency: ReadData SHALL equal mem[index] for the current A.
REQ-014 Read-during-write to the same index: ReadData SHALL show the old word before the edge and the new word immediately after it; there SHALL be no write-through bypass.
REQ-015 A change of WE or WriteData between edges SHALL have no effect on storage.
REQ-016 Address bits above the index field SHALL be handled per REQ-022 and REQ-023.

Reset
REQ-017 While rst_n=0, all words SHALL be cleared to 32'h00000000 asynchronously, and ReadData SHALL be 0.
REQ-018 While rst_n=0, writes SHALL be suppressed even if WE=1.
REQ-019 On reset release, the first write SHALL take effect on the first rising edge with rst_n=1 and WE=1.
REQ-020 A reset asserted mid-operation SHALL discard all prior contents.

Configuration
REQ-021 The macro DMEM_BOUNDS_CHECK_EN SHALL select the out-of-range behaviour.
REQ-022 With DMEM_BOUNDS_CHECK_EN defined, an address with A >= 4*DEPTH_WORDS SHALL read 32'h00000000 and SHALL have any write ignored.
REQ-023 Without DMEM_BOUNDS_CHECK_EN, upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.

Structure
REQ-024 Shared package dmem_pkg SHALL hold DATA_W=32, the DEFAULT_DEPTH_WORDS=64 constant, a word_t typedef (32-bit) and an index-extraction function.
REQ-025 Sub-module dmem_addr_decode SHALL produce the word index and, when DMEM_BOUNDS_CHECK_EN is defined, an in_range flag.
REQ-026 The storage array, write process and read mux SHALL reside in data_memory.

Verification
REQ-027 Reset then A=0x0, WriteData=0xDEADBEEF, WE=1 for one edge, then WE=0 -> ReadData=0xDEADBEEF after that edge and it SHALL persist.
REQ-028 WE=0, A=0x4, WriteData=0x12345678 across several edges -> ReadData=0x00000000 at A=0x4.
REQ-029 Write 0xCAFEF00D at A=0x8, then read at A=0x9, 0xA and 0xB -> ReadData=0xCAFEF00D each time.
REQ-030 Write 0x11111111 at A=0x0, then assert rst_n=0 between edges -> ReadData=0 immediately; WE=1 during reset SHALL leave all words 0.
REQ-031 With 0xAAAAAAAA stored at index 0, write 0x55555555 to A=0x0 -> ReadData=0xAAAAAAAA before the edge and 0x55555555 after it.
REQ-032 With DEPTH_WORDS=64, write 0x0BADF00D at A=0x100 -> ReadData=0 at A=0x100 with DMEM_BOUNDS_CHECK_EN defined; without it, word 0 SHALL read 0x0BADF00D.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory.
// Out-of-range handling is selected by DMEM_BOUNDS_CHECK_EN (see data_memory).
package dmem_pkg;

  localparam int DATA_W              = 32;
  localparam int DEFAULT_DEPTH_WORDS = 64;
  localparam int MAX_ADDR_W          = 64;

  typedef logic [DATA_W-1:0] word_t;

  // Drops the byte offset, then keeps only the bits that select a word.
  function automatic logic [MAX_ADDR_W-1:0] wordIndex(
    input logic [MAX_ADDR_W-1:0] byteAddr,
    input int unsigned           depthWords
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = MAX_ADDR_W'(depthWords - 1);
    return (byteAddr >> 2) & mask;
  endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte-address to word-index decode for data_memory.
// With DMEM_BOUNDS_CHECK_EN defined it also flags addresses inside the array.
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic [ADDR_W-1:0] byteAddr,
  output logic [IDX_W-1:0]  wordIdx
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic              inRange
`endif
);

  assign wordIdx = IDX_W'(wordIndex(MAX_ADDR_W'(byteAddr), DEPTH_WORDS));

`ifdef DMEM_BOUNDS_CHECK_EN
  // Anything at or above 4*DEPTH_WORDS has a nonzero bit above the index field.
  assign inRange = ((byteAddr >> (IDX_W + 2)) == '0);
`endif

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, async clear.
// DMEM_BOUNDS_CHECK_EN: reads above the array return 0 and writes there are dropped;
// otherwise upper address bits are ignored and addresses wrap.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  word_t             WriteData,
  input  logic              WE,
  output word_t             ReadData
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  word_t            mem [DEPTH_WORDS];
  logic [IDX_W-1:0] wordIdx;
  logic             accessOk;
  logic             writeEn;

`ifdef DMEM_BOUNDS_CHECK_EN
  dmem_addr_decode #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) uDecode (
    .byteAddr (A),
    .wordIdx  (wordIdx),
    .inRange  (accessOk)
  );
`else
  dmem_addr_decode #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) uDecode (
    .byteAddr (A),
    .wordIdx  (wordIdx)
  );

  assign accessOk = 1'b1;
`endif

  assign writeEn = WE & accessOk;

  // Whole array clears asynchronously so a reset discards every stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEn) begin
      mem[wordIdx] <= WriteData;
    end
  end

  // No write-through: a same-index write shows up only after the edge.
  assign ReadData = accessOk ? mem[wordIdx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected words, monitor compares.
module tb_data_memory;
  import dmem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  word_t       WriteData;
  logic        WE;
  word_t       ReadData;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sbEntry_t;

  sbEntry_t sb[$];
  logic     sampleReq;
  int       compared   = 0;
  int       mismatched = 0;

  data_memory #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .WriteData (WriteData),
    .WE        (WE),
    .ReadData  (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples mid-cycle, away from the write edge.
  always @(negedge clk) begin
    if (sampleReq) begin
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_underflow: sample requested with empty scoreboard, ReadData=%h", ReadData);
      end else begin
        sbEntry_t e;
        e = sb.pop_front();
        compared++;
        if (ReadData !== e.exp) begin
          mismatched++;
          $display("FAIL %s: got %h expected %h (A=%h)", e.name, ReadData, e.exp, A);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic expectNow(input logic [31:0] exp, input string name);
    sbEntry_t e;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    sampleReq = 1'b1;
    @(posedge clk);
    #1;
    sampleReq = 1'b0;
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp, input string name);
    A  = addr;
    WE = 1'b0;
    expectNow(exp, name);
  endtask

  task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
    A         = addr;
    WriteData = data;
    WE        = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sampleReq = 1'b0;
    rst_n     = 1'b0;
    WE        = 1'b0;
    A         = '0;
    WriteData = '0;
    @(posedge clk);
    #1;
    expectNow(32'h0, "reset_state");
    rst_n = 1'b1;

    // First write right after reset release, then persistence
    writeWord(32'h0, 32'hDEADBEEF);
    readCheck(32'h0, 32'hDEADBEEF, "write_word0");
    WriteData = 32'h0F0F0F0F;
    repeat (3) @(posedge clk);
    #1;
    readCheck(32'h0, 32'hDEADBEEF, "word0_persist");

    // WE low across several edges
    A = 32'h4; WriteData = 32'h12345678; WE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    readCheck(32'h4, 32'h0, "we_low_no_write");

    // Byte offset ignored
    writeWord(32'h8, 32'hCAFEF00D);
    readCheck(32'h9, 32'hCAFEF00D, "offset_1");
    readCheck(32'hA, 32'hCAFEF00D, "offset_2");
    readCheck(32'hB, 32'hCAFEF00D, "offset_3");
    writeWord(32'hF, 32'h01020304);
    readCheck(32'hC, 32'h01020304, "misaligned_write");

    // WE pulse that ends before the edge must not write
    A = 32'h10; WriteData = 32'h99999999; WE = 1'b1;
    #2;
    WE = 1'b0;
    @(posedge clk);
    #1;
    readCheck(32'h10, 32'h0, "we_glitch_between_edges");

    // Read during write: old before edge, new after
    writeWord(32'h0, 32'hAAAAAAAA);
    A = 32'h0; WriteData = 32'h55555555; WE = 1'b1;
    expectNow(32'hAAAAAAAA, "rdw_before_edge");
    WE = 1'b0;
    readCheck(32'h0, 32'h55555555, "rdw_after_edge");

    writeWord(32'hFC, 32'h77777777);
    readCheck(32'hFC, 32'h77777777, "top_word");

    // Mid-operation reset
    writeWord(32'h0, 32'h11111111);
    A = 32'h0;
    rst_n = 1'b0;
    expectNow(32'h0, "reset_immediate");
    A = 32'h8; WriteData = 32'hFFFFFFFF; WE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    readCheck(32'h8, 32'h0, "write_during_reset");
    rst_n = 1'b1;
    readCheck(32'h8, 32'h0, "after_reset_word2");
    readCheck(32'hFC, 32'h0, "after_reset_top");
    readCheck(32'hC, 32'h0, "after_reset_word3");
    writeWord(32'h14, 32'h13572468);
    readCheck(32'h14, 32'h13572468, "first_write_after_reset");

    // Out-of-range address
    writeWord(32'h100, 32'h0BADF00D);
`ifdef DMEM_BOUNDS_CHECK_EN
    readCheck(32'h100, 32'h0, "oor_read");
    readCheck(32'h0, 32'h0, "oor_no_alias");
`else
    readCheck(32'h100, 32'h0BADF00D, "wrap_read");
    readCheck(32'h0, 32'h0BADF00D, "wrap_word0");
`endif
    readCheck(32'h14, 32'h13572468, "oor_untouched");

    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: %0d entries not compared, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
